// File: rtl/memory_sequencer.sv
// memory_sequencer: memory-game round controller (pattern fill, paced playback, press checking, win/lose).
module memory_sequencer #(
  parameter int          MAX_LEN       = 16,
  parameter int          ON_TICKS      = 2,
  parameter int          OFF_TICKS     = 1,
  parameter int          TIMEOUT_TICKS = 10,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_slow,
  input  logic       start,
  input  logic       btn_valid,
  input  logic [1:0] btn_sym,
  output logic [3:0] led_onehot,
  output logic [5:0] level,
  output logic       showing,
  output logic       wait_input,
  output logic       win,
  output logic       lose
);
  localparam int IW   = $clog2(MAX_LEN);
  localparam int TMAX = (TIMEOUT_TICKS > ON_TICKS ? TIMEOUT_TICKS : ON_TICKS) > OFF_TICKS ?
                        (TIMEOUT_TICKS > ON_TICKS ? TIMEOUT_TICKS : ON_TICKS) : OFF_TICKS;
  localparam int CW   = $clog2(TMAX + 1);
  typedef enum logic [2:0] {IDLE, FILL, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE} state_e;
  state_e                  state_q;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [MAX_LEN-1:0][1:0] pat_q;
  logic [IW-1:0]           idx_q, fill_q;
  logic [5:0]              level_q;
  logic [CW-1:0]           cnt_q;
  logic                    pre_q;
  logic                    more;
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign more   = 6'(idx_q) + 6'd1 < level_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      idx_q   <= '0;
      fill_q  <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, WIN, LOSE: if (start) begin
          state_q <= FILL;
          lfsr_q  <= SEED;
          fill_q  <= '0;
          idx_q   <= '0;
          level_q <= '0;
          cnt_q   <= '0;
        end
        FILL: begin
          lfsr_q        <= lfsr_d;
          pat_q[fill_q] <= lfsr_d[1:0];
          fill_q        <= fill_q + IW'(1);
          if (fill_q == IW'(MAX_LEN - 1)) begin
            state_q <= SHOW_OFF;
            level_q <= 6'd1;
            idx_q   <= '0;
            pre_q   <= 1'b1;
            cnt_q   <= '0;
          end
        end
        SHOW_OFF: if (tick_slow) begin
          if (cnt_q == CW'(OFF_TICKS - 1)) begin
            cnt_q <= '0;
            pre_q <= 1'b0;
            if (pre_q) state_q <= SHOW_ON;
            else if (more) begin
              state_q <= SHOW_ON;
              idx_q   <= idx_q + IW'(1);
            end else begin
              state_q <= INPUT;
              idx_q   <= '0;
            end
          end else cnt_q <= cnt_q + CW'(1);
        end
        SHOW_ON: if (tick_slow) begin
          if (cnt_q == CW'(ON_TICKS - 1)) begin
            cnt_q   <= '0;
            state_q <= SHOW_OFF;
          end else cnt_q <= cnt_q + CW'(1);
        end
        INPUT: if (btn_valid) begin
          // a press always takes priority over a coincident final timeout tick
          cnt_q <= '0;
          if (btn_sym != pat_q[idx_q]) state_q <= LOSE;
          else if (more) idx_q <= idx_q + IW'(1);
          else if (level_q == 6'(MAX_LEN)) state_q <= WIN;
          else begin
            level_q <= level_q + 6'd1;
            idx_q   <= '0;
            pre_q   <= 1'b1;
            state_q <= SHOW_OFF;
          end
        end else if (tick_slow) begin
          if (cnt_q == CW'(TIMEOUT_TICKS - 1)) begin
            cnt_q   <= '0;
            state_q <= LOSE;
          end else cnt_q <= cnt_q + CW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign led_onehot = state_q == SHOW_ON ? 4'b0001 << pat_q[idx_q] : 4'b0000;
  assign level      = level_q;
  assign showing    = state_q == FILL || state_q == SHOW_ON || state_q == SHOW_OFF;
  assign wait_input = state_q == INPUT;
  assign win        = state_q == WIN;
  assign lose       = state_q == LOSE;
endmodule

// File: tb/tb_memory_sequencer.sv
// tb_memory_sequencer: randomized scenario bench for memory_sequencer against a phase-timeline model.
module tb_memory_sequencer;
  localparam int ML = 4, ON = 2, OFF = 1, TO = 4;
  logic clk = 1'b0, rst, tick_slow, start, btn_valid, showing, wait_input, win, lose;
  logic [1:0] btn_sym;
  logic [3:0] led_onehot;
  logic [5:0] level;
  logic [1:0] pat [ML];
  int checks = 0, failures = 0;
  typedef struct {logic [3:0] led; int dur;} ph_t;
  always #5 clk = ~clk;
  memory_sequencer #(.MAX_LEN(ML), .ON_TICKS(ON), .OFF_TICKS(OFF), .TIMEOUT_TICKS(TO), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .tick_slow(tick_slow), .start(start), .btn_valid(btn_valid), .btn_sym(btn_sym),
    .led_onehot(led_onehot), .level(level), .showing(showing), .wait_input(wait_input), .win(win), .lose(lose));
  function automatic logic [13:0] outs();
    return {led_onehot, showing, wait_input, win, lose, level};
  endfunction
  function automatic logic [13:0] ev(logic [3:0] led, logic sh, logic wi, logic w, logic l, logic [5:0] lv);
    return {led, sh, wi, w, l, lv};
  endfunction
  function automatic void build_pat();
    logic [15:0] r = 16'hACE1;
    for (int i = 0; i < ML; i++) begin
      r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
      pat[i] = r[1:0];
    end
  endfunction
  task automatic cyc(input logic t, input logic s, input logic b, input logic [1:0] sym);
    tick_slow = t; start = s; btn_valid = b; btn_sym = sym;
    @(posedge clk); #1;
    tick_slow = 1'b0; start = 1'b0; btn_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 2'd3);
    rst = 1'b0;
    checks++;
    if (outs() !== 14'd0) begin failures++; $display("FAIL reset: got %h want %h", outs(), 14'd0); end
  endtask
  task automatic test_fill(input logic strict, input logic t0);
    cyc(t0, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < ML; i++) begin
      checks++;
      if (strict ? outs() !== ev(0, 1, 0, 0, 0, 0) : outs()[13:6] !== 8'b0000_1000) begin
        failures++; $display("FAIL fill cycle %0d: got %h want showing only", i, outs());
      end
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
    end
    checks++;
    if (outs() !== ev(0, 1, 0, 0, 0, 1)) begin
      failures++; $display("FAIL fill_end: got %h want %h", outs(), ev(0, 1, 0, 0, 0, 1));
    end
  endtask
  task automatic play_round(input int lv);
    ph_t q[$];
    q.push_back('{4'b0, OFF});
    for (int i = 0; i < lv; i++) begin
      q.push_back('{4'b0001 << pat[i], ON});
      q.push_back('{4'b0, OFF});
    end
    foreach (q[p]) begin
      for (int t = 0; t < q[p].dur; t++) begin
        for (int g = int'($urandom_range(0, 3)); g >= 0; g--) begin
          checks++;
          if (outs() !== ev(q[p].led, 1, 0, 0, 0, 6'(lv))) begin
            failures++; $display("FAIL play lv%0d phase %0d: got %h want %h", lv, p, outs(), ev(q[p].led, 1, 0, 0, 0, 6'(lv)));
          end
          if (lv == 1 && q[p].led != 4'b0) begin
            checks++;
            if (led_onehot !== 4'b1000) begin failures++; $display("FAIL first_symbol: got %b want 1000", led_onehot); end
          end
          if (g > 0) cyc(1'b0, 1'($urandom), 1'($urandom), 2'($urandom));
        end
        cyc(1'b1, 1'($urandom), 1'($urandom), 2'($urandom));
      end
    end
    checks++;
    if (outs() !== ev(0, 0, 1, 0, 0, 6'(lv))) begin
      failures++; $display("FAIL play_to_input lv%0d: got %h want %h", lv, outs(), ev(0, 0, 1, 0, 0, 6'(lv)));
    end
  endtask
  task automatic press_round(input int lv, input int bad_at);
    logic [1:0] sym;
    for (int i = 0; i < lv; i++) begin
      for (int k = int'($urandom_range(0, TO - 1)); k > 0; k--) begin
        repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0, 1'b0, 2'd0);
        cyc(1'b1, 1'b0, 1'b0, 2'd0);
        checks++;
        if (outs() !== ev(0, 0, 1, 0, 0, 6'(lv))) begin
          failures++; $display("FAIL input_wait lv%0d: got %h want %h", lv, outs(), ev(0, 0, 1, 0, 0, 6'(lv)));
        end
      end
      sym = (i == bad_at) ? pat[i] ^ 2'($urandom_range(1, 3)) : pat[i];
      cyc(1'b0, 1'b0, 1'b1, sym);
      checks++;
      if (i == bad_at) begin
        if (outs() !== ev(0, 0, 0, 0, 1, 6'(lv))) begin
          failures++; $display("FAIL wrong_press: got %h want %h", outs(), ev(0, 0, 0, 0, 1, 6'(lv)));
        end
        return;
      end else if (i < lv - 1) begin
        if (outs() !== ev(0, 0, 1, 0, 0, 6'(lv))) begin
          failures++; $display("FAIL mid_press lv%0d: got %h want %h", lv, outs(), ev(0, 0, 1, 0, 0, 6'(lv)));
        end
      end else if (lv == ML) begin
        if (outs() !== ev(0, 0, 0, 1, 0, 6'(lv))) begin
          failures++; $display("FAIL win: got %h want %h", outs(), ev(0, 0, 0, 1, 0, 6'(lv)));
        end
      end else if (outs() !== ev(0, 1, 0, 0, 0, 6'(lv + 1))) begin
        failures++; $display("FAIL advance lv%0d: got %h want %h", lv, outs(), ev(0, 1, 0, 0, 0, 6'(lv + 1)));
      end
    end
  endtask
  task automatic test_timeout(input int lv);
    for (int k = 1; k <= TO; k++) begin
      repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0, 1'b0, 2'd0);
      cyc(1'b1, 1'b0, 1'b0, 2'd0);
      checks++;
      if (outs() !== (k < TO ? ev(0, 0, 1, 0, 0, 6'(lv)) : ev(0, 0, 0, 0, 1, 6'(lv)))) begin
        failures++; $display("FAIL timeout tick %0d: got %h", k, outs());
      end
    end
    repeat (3) begin
      cyc(1'($urandom), 1'b0, 1'($urandom), 2'($urandom));
      checks++;
      if (outs() !== ev(0, 0, 0, 0, 1, 6'(lv))) begin
        failures++; $display("FAIL lose_hold: got %h want %h", outs(), ev(0, 0, 0, 0, 1, 6'(lv)));
      end
    end
  endtask
  task automatic test_tie();
    repeat (TO - 1) cyc(1'b1, 1'b0, 1'b0, 2'd0);
    cyc(1'b1, 1'b0, 1'b1, pat[0]);
    checks++;
    if (outs() !== ev(0, 1, 0, 0, 0, 2)) begin
      failures++; $display("FAIL tie: got %h want %h", outs(), ev(0, 1, 0, 0, 0, 2));
    end
  endtask
  task automatic test_win_hold();
    repeat (3) begin
      cyc(1'($urandom), 1'b0, 1'($urandom), 2'($urandom));
      checks++;
      if (outs() !== ev(0, 0, 0, 1, 0, ML)) begin
        failures++; $display("FAIL win_hold: got %h want %h", outs(), ev(0, 0, 0, 1, 0, ML));
      end
    end
  endtask
  task automatic test_reset_mid();
    cyc(1'b1, 1'b0, 1'b0, 2'd0);
    checks++;
    if (led_onehot !== 4'b0001 << pat[0]) begin
      failures++; $display("FAIL reach_show_on: got %b want %b", led_onehot, 4'b0001 << pat[0]);
    end
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 2'($urandom));
    rst = 1'b0;
    checks++;
    if (outs() !== 14'd0) begin failures++; $display("FAIL reset_mid: got %h want %h", outs(), 14'd0); end
    cyc(1'b1, 1'b0, 1'b1, 2'($urandom));
    checks++;
    if (outs() !== 14'd0) begin failures++; $display("FAIL idle_ignore: got %h want %h", outs(), 14'd0); end
  endtask
  initial begin
    rst = 1'b1; tick_slow = 1'b0; start = 1'b0; btn_valid = 1'b0; btn_sym = 2'd0;
    build_pat();
    test_reset();
    test_fill(1'b1, 1'($urandom));
    play_round(1);
    press_round(1, -1);
    play_round(2);
    test_timeout(2);
    test_fill(1'b0, 1'b1);
    play_round(1);
    test_tie();
    play_round(2);
    press_round(2, int'($urandom_range(0, 1)));
    test_fill(1'b0, 1'($urandom));
    for (int lv = 1; lv <= ML; lv++) begin
      play_round(lv);
      press_round(lv, -1);
    end
    test_win_hold();
    test_fill(1'b0, 1'b1);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
